alu_sweep_driver: RTL and testbench
===================================

Name: alu_sweep_driver

Overview:
- Sequential initiator for the 2-bit-opcode, 8-bit-operand ALU interface (op, a, b in; out back).
- On start, it walks every (op, a, b) combination for the selected opcodes and drives one vector per clock.
- It samples the ALU result each cycle and compresses the results into a rotating-XOR signature, for on-chip self-test of the ALU.
- It sits beside the ALU, with its op/a/b outputs wired to the ALU inputs and the ALU result wired back in.

Parameters:
- WIDTH, 8: operand and result width.
- OPW, 2: opcode width. The number of opcodes is 2^OPW.
- SIG_W, 16: signature register width. Must be at least WIDTH.
- SEED, 16'hFFFF: signature value after reset and on each start.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep. Accepted only in IDLE or DONE.
- abort  in  1  terminates an active sweep.
- op_en  in  2^OPW  per-opcode enable mask. Bit k set means opcode k is swept. Sampled only when start is accepted.
- alu_op  out  OPW  opcode driven to the ALU.
- alu_a  out  WIDTH  operand a driven to the ALU.
- alu_b  out  WIDTH  operand b driven to the ALU.
- alu_vld  out  1  high when alu_op/alu_a/alu_b hold a live vector.
- alu_out  in  WIDTH  combinational ALU result for the currently driven vector.
- busy  out  1  high in RUN.
- done  out  1  high in DONE until the next accepted start.
- sig  out  SIG_W  running signature.
- vec_cnt  out  OPW+2*WIDTH+1  number of vectors sampled in the current or last sweep.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - alu_op, alu_a, alu_b, alu_vld, busy, done and vec_cnt go to 0.
  - sig goes to SEED.
- Registers: every output is driven directly from a register; no combinational path from input to output.
- FSM has three states: IDLE, RUN, DONE.
- IDLE or DONE, start=1:
  - Latch op_en. Clear vec_cnt. Load sig with SEED.
  - If the latched mask is 0: go to DONE next cycle with vec_cnt=0 and sig=SEED.
  - Otherwise go to RUN with alu_op = lowest enabled opcode, alu_a=0, alu_b=0, alu_vld=1, busy=1, done=0.
- RUN, each cycle with abort=0:
  - Sample alu_out.
  - sig <= {sig[SIG_W-2:0], sig[SIG_W-1]} ^ zero_extend(alu_out).
  - vec_cnt <= vec_cnt + 1.
  - Advance the vector: b is innermost and steps by 1. When b=max it wraps to 0 and a steps by 1. When a=b=max, op steps to the next enabled opcode in ascending order; disabled opcodes are skipped with no dead cycle.
- Completion:
  - When the vector just sampled is (last enabled op, max, max), the next state is DONE.
  - On entry to DONE: alu_vld=0 and busy=0; done=1.
  - alu_op/alu_a/alu_b hold their last values.
- Latency: the first vector is driven the cycle after start. The sweep occupies popcount(mask) * 2^(2*WIDTH) RUN cycles, one vector per cycle with no bubbles. done rises on the cycle after the last sample.
- abort:
  - In RUN: abort has priority over sampling; the current vector is not sampled. Next state is IDLE with alu_vld=0, busy=0, done=0. sig and vec_cnt are held.
  - In IDLE or DONE: ignored.
- Simultaneous start and abort in IDLE or DONE: start wins.
- start during RUN: ignored.
- Reset mid-sweep: immediate return to the reset values. There is no resumption.
- The ALU result for op=2 with b=0 (modulo by zero) is treated as ordinary data. The block does not skip or flag it.

Decomposition:
- Shared package alu_pkg holds:
  - typedef alu_op_e with values OP_XOR=0, OP_SHL=1, OP_MOD=2, OP_NAND=3.
  - Width constants ALU_W=8 and ALU_OPW=2.
  - typedef sweep_state_e with values IDLE, RUN, DONE.
- One sub-module, sweep_sig_lfsr, holds the signature register with load-seed and update-enable inputs.
- The opcode priority pick (next enabled opcode above the current one) stays in the top level.

Test Plan:
- Reset: hold rst_n=0 with clk running. Expect alu_vld=busy=done=0, vec_cnt=0, sig=16'hFFFF. Release rst_n; outputs are unchanged until start.
- Empty mask: op_en=4'b0000 with start pulse at cycle t. Expect done=1 at t+1, busy never set, vec_cnt=0, sig=16'hFFFF.
- Null result: op_en=4'b0001 with alu_out tied to 0.
  - Expect busy for exactly 65536 cycles.
  - First vector is (0,0,0); last is (0,255,255).
  - At end: done=1, vec_cnt=65536, sig=16'hFFFF.
- Skip order: op_en=4'b0101 with a real ALU model that returns 0 for mod by 0.
  - Vector 65535 is (0,255,255); vector 65536 is (2,0,0).
  - Total vectors 131072.
  - sig equals the software model of the same rotate-XOR fold.
- Abort: op_en=4'b1111 with abort asserted on the 101st RUN cycle.
  - Next cycle: IDLE, alu_vld=0, done=0, vec_cnt=100, sig equal to the model after 100 samples.
  - A subsequent start sweeps from (0,0,0) with sig reset to SEED.
- Mid-sweep events:
  - start pulsed during RUN is ignored; the sweep completes with the normal count.
  - rst_n dropped during RUN clears all outputs asynchronously, before the next clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU and its self-test sweep driver.
package alu_pkg;

    localparam int ALU_W   = 8;
    localparam int ALU_OPW = 2;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_SHL  = 2'd1,
        OP_MOD  = 2'd2,
        OP_NAND = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/sweep_sig_lfsr.sv
// Rotate-left-and-XOR signature register folding ALU results.
module sweep_sig_lfsr #(
    parameter int               WIDTH = 8,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(data_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/alu_sweep_driver.sv
// Exhaustive (op, a, b) sweep driver for ALU self-test with signature capture.
module alu_sweep_driver
    import alu_pkg::*;
#(
    parameter int               WIDTH = ALU_W,
    parameter int               OPW   = ALU_OPW,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
    localparam int              NOP   = 2**OPW,
    localparam int              CW    = OPW + 2*WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [NOP-1:0]   op_en,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_vld,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig,
    output logic [CW-1:0]    vec_cnt
);

    sweep_state_e     state_q, state_d;
    logic [NOP-1:0]   mask_q, mask_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sig_load;
    logic             sig_en;
    logic [OPW-1:0]   nxt_op;
    logic             has_nxt;
    logic [OPW-1:0]   first_op;

    // Descending scan so the lowest qualifying opcode is the last one written.
    always_comb begin
        nxt_op   = '0;
        has_nxt  = 1'b0;
        first_op = '0;
        for (int k = NOP - 1; k >= 0; k--) begin
            if (mask_q[k] && (k[OPW-1:0] > op_q)) begin
                nxt_op  = k[OPW-1:0];
                has_nxt = 1'b1;
            end
            if (op_en[k]) begin
                first_op = k[OPW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        vld_d    = vld_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        sig_load = 1'b0;
        sig_en   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mask_d   = op_en;
                    cnt_d    = '0;
                    sig_load = 1'b1;
                    vld_d    = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b0;
                    if (op_en == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        op_d    = first_op;
                        a_d     = '0;
                        b_d     = '0;
                        vld_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    sig_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    b_d    = b_q + 1'b1;
                    if (b_q == '1) begin
                        a_d = a_q + 1'b1;
                        if (a_q == '1) begin
                            if (has_nxt) begin
                                op_d = nxt_op;
                            end else begin
                                // Last vector sampled: freeze the bus for inspection.
                                state_d = DONE;
                                a_d     = a_q;
                                b_d     = b_q;
                                vld_d   = 1'b0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    sweep_sig_lfsr #(
        .WIDTH (WIDTH),
        .SIG_W (SIG_W),
        .SEED  (SEED)
    ) u_sig (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (sig_load),
        .en_i   (sig_en),
        .data_i (alu_out),
        .sig_o  (sig)
    );

    assign alu_op  = op_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_vld = vld_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign vec_cnt = cnt_q;

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed bench for alu_sweep_driver at a reduced 4-bit operand width.
module tb_alu_sweep_driver;
    import alu_pkg::*;

    localparam int W   = 4;
    localparam int OPW = 2;
    localparam int SW  = 16;
    localparam int NOP = 4;
    localparam int CW  = OPW + 2*W + 1;
    localparam int BLK = 1 << (2*W);
    localparam int VW  = OPW + 2*W;
    localparam logic [SW-1:0] SEED = 16'hFFFF;

    typedef struct {
        logic [NOP-1:0] mask;
        logic           zero;
        int             cyc;
        logic [SW-1:0]  sg;
    } sweep_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [NOP-1:0] op_en = '0;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_a, alu_b, alu_out;
    logic           alu_vld, busy, done;
    logic [SW-1:0]  sig;
    logic [CW-1:0]  vec_cnt;
    logic           zero_alu = 1'b1;
    logic [VW-1:0]  seen [0:2047];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_sweep_driver #(
        .WIDTH (W),
        .OPW   (OPW),
        .SIG_W (SW),
        .SEED  (SEED)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .op_en   (op_en),
        .alu_op  (alu_op),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_vld (alu_vld),
        .alu_out (alu_out),
        .busy    (busy),
        .done    (done),
        .sig     (sig),
        .vec_cnt (vec_cnt)
    );

    function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (alu_op_e'(op))
            OP_XOR:  return a ^ b;
            OP_SHL:  return a << b;
            OP_MOD:  return (b == '0) ? '0 : a % b;
            default: return ~(a & b);
        endcase
    endfunction

    always_comb alu_out = zero_alu ? '0 : alu_f(alu_op, alu_a, alu_b);

    function automatic logic [VW-1:0] exp_vec(input logic [NOP-1:0] mask,
                                              input int idx);
        int blk, r, n;
        logic [OPW-1:0] op;
        blk = idx / BLK;
        r = idx % BLK;
        n = 0;
        op = '0;
        for (int k = 0; k < NOP; k++) begin
            if (mask[k]) begin
                if (n == blk) op = k[OPW-1:0];
                n++;
            end
        end
        return {op, W'(r / (1 << W)), W'(r % (1 << W))};
    endfunction

    function automatic logic [SW-1:0] model_sig(input logic [NOP-1:0] mask,
                                                input logic zero,
                                                input int n);
        logic [SW-1:0] s;
        logic [VW-1:0] v;
        logic [W-1:0]  d;
        s = SEED;
        for (int i = 0; i < n; i++) begin
            v = exp_vec(mask, i);
            d = zero ? '0 : alu_f(v[VW-1:2*W], v[2*W-1:W], v[W-1:0]);
            s = {s[SW-2:0], s[SW-1]} ^ SW'(d);
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input logic [NOP-1:0] mask, input logic zero,
                             input int poke, output int cycles,
                             output int seq_bad);
        zero_alu = zero;
        op_en = mask;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_en = '0;
        cycles = 0;
        seq_bad = 0;
        while (busy && cycles < 2000) begin
            seen[cycles] = {alu_op, alu_a, alu_b};
            if (alu_vld !== 1'b1 || {alu_op, alu_a, alu_b} !== exp_vec(mask, cycles))
                seq_bad++;
            start = (cycles == poke);
            tick();
            cycles++;
        end
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sweep_t tbl [5];
        int cyc, sb;

        tbl[0] = '{4'b0000, 1'b1, 0,       SEED};
        tbl[1] = '{4'b0001, 1'b1, BLK,     SEED};
        tbl[2] = '{4'b1000, 1'b0, BLK,     model_sig(4'b1000, 1'b0, BLK)};
        tbl[3] = '{4'b1111, 1'b0, 4 * BLK, model_sig(4'b1111, 1'b0, 4 * BLK)};
        tbl[4] = '{4'b0101, 1'b0, 2 * BLK, model_sig(4'b0101, 1'b0, 2 * BLK)};

        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_vld", alu_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", vec_cnt, 0);
        chk("rst_sig", sig, SEED);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_vld", alu_vld, 0);
        chk("post_rst_sig", sig, SEED);

        for (int i = 0; i < 5; i++) begin
            run_sweep(tbl[i].mask, tbl[i].zero, -1, cyc, sb);
            chk($sformatf("sweep%0d_cycles", i), cyc, tbl[i].cyc);
            chk($sformatf("sweep%0d_seq", i), sb, 0);
            chk($sformatf("sweep%0d_done", i), done, 1);
            chk($sformatf("sweep%0d_vld", i), alu_vld, 0);
            chk($sformatf("sweep%0d_cnt", i), vec_cnt, tbl[i].cyc);
            chk($sformatf("sweep%0d_sig", i), sig, tbl[i].sg);
            if (tbl[i].cyc > 0)
                chk($sformatf("sweep%0d_hold", i), {alu_op, alu_a, alu_b},
                    exp_vec(tbl[i].mask, tbl[i].cyc - 1));
        end
        chk("skip_v255", seen[255], 10'h0FF);
        chk("skip_v256", seen[256], 10'h200);
        chk("skip_v511", seen[511], 10'h2FF);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_done", done, 1);

        zero_alu = 1'b0;
        op_en = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_en = '0;
        repeat (100) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_vld", alu_vld, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", vec_cnt, 100);
        chk("abort_sig", sig, model_sig(4'b1111, 1'b0, 100));
        tick();
        chk("abort_idle_cnt", vec_cnt, 100);

        op_en = 4'b1111;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_vec", {alu_op, alu_a, alu_b}, 0);
        chk("restart_sig", sig, SEED);
        chk("restart_cnt", vec_cnt, 0);

        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_vld", alu_vld, 0);
        chk("arst_cnt", vec_cnt, 0);
        chk("arst_sig", sig, SEED);
        chk("arst_vec", {alu_op, alu_a, alu_b}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_sweep(4'b0010, 1'b0, 50, cyc, sb);
        chk("poke_cycles", cyc, BLK);
        chk("poke_seq", sb, 0);
        chk("poke_cnt", vec_cnt, BLK);
        chk("poke_sig", sig, model_sig(4'b0010, 1'b0, BLK));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
